main_ripple_up_counter: RTL and testbench



---
 rtl/main_ripple_up_counter.sv | 36 +++
 tb/tb_main_ripple_up_counter.sv | 107 ++++++++++
 2 files changed

// File: rtl/main_ripple_up_counter.sv
// Free-running WIDTH-bit up counter built from toggle stages, all clocked by clk.
// Bit i toggles when every lower bit is 1, so the count is always current value + 1.
module main_ripple_up_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] count
);

  // Power-up value gives a defined count before any reset is applied.
  logic [WIDTH-1:0] r_count = '0;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_count_next;

  assign w_toggle[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    assign w_toggle[i] = &r_count[i-1:0];
  end

  always_comb begin
    w_count_next = r_count ^ w_toggle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_main_ripple_up_counter.sv
// Bench for main_ripple_up_counter: directed reset/wrap/glitch steps, then random reset
// traffic checked against an arithmetic modulo-2**WIDTH reference model.
module tb_main_ripple_up_counter;

  localparam int unsigned WIDTH = 3;
  localparam int          MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] count;

  int n_vec   = 0;
  int n_err   = 0;
  int exp_cnt = 0;

  main_ripple_up_counter #(
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .count(count)
  );

  // First rising edge at 20 ns, 20 ns period.
  initial begin
    clk = 1'b0;
    #10;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input int expv);
    logic [WIDTH-1:0] e;
    e = expv[WIDTH-1:0];
    n_vec++;
    assert (count === e)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, count, e);
    end
  endtask

  // Advance one rising edge, update the reference from rst_n at that edge, check 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    exp_cnt = rst_n ? (exp_cnt + 1) % MOD : 0;
    #1;
    check(tag, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b1;

    // No reset from t=0: starts at 0, counts from the first edge.
    #5;
    check("powerup_zero", 0);
    for (int i = 0; i < 7; i++) begin
      tick("powerup_run");
      check("powerup_lit", i + 1);
    end

    // Reset held for two edges.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick("reset_hold");
      check("reset_hold_lit", 0);
    end

    // Release and run 16 edges; wraps 7->0 at edges 8 and 16.
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick("release_run");
      check("release_lit", (i + 1) % MOD);
    end

    // Pulse reset at count==5.
    for (int i = 0; i < MOD && exp_cnt != 5; i++) tick("seek5");
    check("at5", 5);
    rst_n = 1'b0;
    tick("midreset");
    check("midreset_lit", 0);
    rst_n = 1'b1;
    tick("midrelease");
    check("midrelease_lit", 1);

    // Reset glitch entirely between edges has no effect.
    #3 rst_n = 1'b0;
    #4;
    check("glitch_hold", 1);
    rst_n = 1'b1;
    tick("glitch_next");
    check("glitch_next_lit", 2);

    // Random reset traffic, including occasional between-edge glitches.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      if (rst_n && $urandom_range(0, 9) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
